awgn_channel: RTL
=================

Name: awgn_channel

Overview:
Parametrised, streaming complex AWGN channel for the text_implement link simulation. Adds Gaussian-approximated noise to I and Q samples, with SNR selectable at run time per sample (0..9 dB). Noise is a central-limit sum of four LFSR-derived uniforms, one independent LFSR per rail. Valid/ready handshakes on input and output, a fixed 3-stage pipeline and output saturation.

Parameters:
DW, 12, signed sample width of in_i/in_q/out_i/out_q (8..16)
SEED_I, 32'hACE1_2468, reset value of I-rail LFSR (must be nonzero)
SEED_Q, 32'h1357_BDF0, reset value of Q-rail LFSR (must be nonzero)
NOISE_SHIFT, 8, right shift applied to sum*sigma product (sigma is Q0.8)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_i  in  DW  signed real input
in_q  in  DW  signed imaginary input
snr_db  in  4  SNR select for this sample, captured with it
noise_en  in  1  1 = add noise, 0 = pass-through (captured with sample)
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_i  out  DW  signed real output
out_q  out  DW  signed imaginary output
out_sat  out  1  out_i or out_q was clipped for this sample
sample_cnt  out  32  number of accepted input samples, wraps at 2^32

Behaviour:
- Reset: clk and reset as named; reset synchronous, active-high. On reset: LFSR_I<=SEED_I, LFSR_Q<=SEED_Q; all stage valids 0; out_valid=0, out_i=out_q=0, out_sat=0, sample_cnt=0. Reset mid-stream discards every in-flight sample, with no output for it.
- Pipeline enable: pipe_en = !out_valid || out_ready; in_ready = pipe_en. Accept = in_valid && in_ready. Whole pipeline holds when pipe_en=0; out_* stable while out_valid && !out_ready. Bubbles propagate as invalid stages.
- LFSR: 32-bit Fibonacci, feedback fb = s[31]^s[21]^s[1]^s[0], next = {s[30:0],fb}. Per accept, each LFSR advances exactly 8 single steps, computed combinationally. No advance without accept. Advances regardless of noise_en.
- Uniforms: u0..u3 = bytes [7:0],[15:8],[23:16],[31:24] of the LFSR state before advance. S = u0+u1+u2+u3-510, signed 11 bits, range -510..+510.
- Sigma LUT (Q0.8), snr_db 0..9 -> 180,161,143,128,114,102,90,81,72,64. snr_db>9 uses 64.
- Stage 1 (on accept): register in_i, in_q, S_I, S_Q, sigma, noise_en, valid.
- Stage 2: P = S*sigma (signed 19 bits); noise = P >>> NOISE_SHIFT (arithmetic, floor). Force noise to 0 when noise_en=0.
- Stage 3: sum = x + noise at DW+2 bits. Saturate to [-2^(DW-1), 2^(DW-1)-1]. out_sat = either rail clipped. out_valid = stage-2 valid.
- Latency: exactly 3 cycles from accept to out_valid with no backpressure. Throughput 1 sample/cycle.
- sample_cnt increments on every accept, including during output stall if accept occurs (it cannot, because in_ready=0).
- Simultaneous reset and in_valid: reset wins, sample not accepted, cnt stays 0.
- Order is preserved. No sample is dropped or duplicated under any in_valid/out_ready pattern.

Test Plan:
- noise_en=0, out_ready=1, in_i=100, in_q=-37 accepted at cycle 0 -> out_valid at cycle 3 with out_i=100, out_q=-37, out_sat=0. sample_cnt=1.
- noise_en=1, snr_db=0, 1000 random samples -> out_i/out_q bit-exact to a C/Python model of the LFSR, S, LUT, shift and saturation from SEED_I/SEED_Q.
- DW=12, in_i=2047, noise_en=1, snr_db=0 streamed -> out_i never exceeds 2047. out_sat=1 exactly on samples whose model noise_I>0. Likewise in_i=-2048 for noise<0.
- Backpressure: continuous in_valid, out_ready toggled randomly (including 5-cycle low runs) -> in_ready=0 whenever output is stalled, out_* held stable, output sequence equals the no-stall sequence.
- Statistics: 65536 samples, in=0, snr_db=0 -> noise mean within ±2, std 103.9 ±3%. snr_db=12 gives the same sequence as snr_db=9.
- Reset asserted with 2 samples in flight -> out_valid=0 next cycle, sample_cnt=0. Next accepted sample uses the seed-state LFSR value, identical to the first sample after power-on.

Source files
------------

// File: rtl/awgn_channel.sv
// awgn_channel: streaming complex AWGN channel.
//   Adds Gaussian-approximated noise (sum of four LFSR bytes, one LFSR per
//   rail) scaled by an SNR-selected sigma to each I/Q sample.
//   Fixed 3-stage pipeline, valid/ready on both sides, saturating output.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake
//   in_i, in_q           - signed DW-bit input sample
//   snr_db, noise_en     - per-sample SNR select (0..9 dB) and noise enable
//   out_valid/out_ready  - output handshake
//   out_i, out_q         - signed DW-bit output sample
//   out_sat              - either rail was clipped for this sample
//   sample_cnt           - accepted input sample count (wraps)
module awgn_channel #(
    parameter int          DW          = 12,
    parameter logic [31:0] SEED_I      = 32'hACE1_2468,
    parameter logic [31:0] SEED_Q      = 32'h1357_BDF0,
    parameter int          NOISE_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    input  logic [3:0]           snr_db,
    input  logic                 noise_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q,
    output logic                 out_sat,
    output logic [31:0]          sample_cnt
);

    localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] MINV = {3'b111, {(DW-1){1'b0}}};

    // Eight Fibonacci steps per accepted sample.
    function automatic logic [31:0] lfsr_adv8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int unsigned k = 0; k < 8; k++)
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        return t;
    endfunction

    // Sum of the four state bytes, re-centred to -510..+510.
    function automatic logic signed [10:0] uni_sum(input logic [31:0] s);
        logic [10:0] acc;
        acc = {3'b000, s[7:0]} + {3'b000, s[15:8]}
            + {3'b000, s[23:16]} + {3'b000, s[31:24]};
        return $signed(acc - 11'd510);
    endfunction

    function automatic logic [7:0] sigma_lut(input logic [3:0] snr);
        logic [7:0] sg;
        case (snr)
            4'd0:    sg = 8'd180;
            4'd1:    sg = 8'd161;
            4'd2:    sg = 8'd143;
            4'd3:    sg = 8'd128;
            4'd4:    sg = 8'd114;
            4'd5:    sg = 8'd102;
            4'd6:    sg = 8'd90;
            4'd7:    sg = 8'd81;
            4'd8:    sg = 8'd72;
            default: sg = 8'd64;
        endcase
        return sg;
    endfunction

    logic [31:0] lfsr_i, lfsr_q;
    logic        pipe_en, accept;

    // Stage 1
    logic                 s1_valid, s1_nen;
    logic signed [DW-1:0] s1_i, s1_q;
    logic signed [10:0]   s1_si, s1_sq;
    logic [7:0]           s1_sigma;

    // Stage 2
    logic                 s2_valid;
    logic signed [DW-1:0] s2_i, s2_q;
    logic signed [DW+1:0] s2_ni, s2_nq;

    logic signed [18:0]   p_i, p_q;
    logic signed [DW+1:0] sum_i, sum_q;
    logic signed [DW-1:0] sat_i, sat_q;
    logic                 clip_i, clip_q;

    assign pipe_en  = !out_valid || out_ready;
    assign in_ready = pipe_en;
    assign accept   = in_valid && in_ready;

    assign p_i = $signed({{8{s1_si[10]}}, s1_si}) * $signed({11'b0, s1_sigma});
    assign p_q = $signed({{8{s1_sq[10]}}, s1_sq}) * $signed({11'b0, s1_sigma});

    always_comb begin
        sum_i  = {{2{s2_i[DW-1]}}, s2_i} + s2_ni;
        sum_q  = {{2{s2_q[DW-1]}}, s2_q} + s2_nq;
        clip_i = 1'b0;
        clip_q = 1'b0;
        sat_i  = sum_i[DW-1:0];
        sat_q  = sum_q[DW-1:0];
        if (sum_i > MAXV) begin
            sat_i  = MAXV[DW-1:0];
            clip_i = 1'b1;
        end else if (sum_i < MINV) begin
            sat_i  = MINV[DW-1:0];
            clip_i = 1'b1;
        end
        if (sum_q > MAXV) begin
            sat_q  = MAXV[DW-1:0];
            clip_q = 1'b1;
        end else if (sum_q < MINV) begin
            sat_q  = MINV[DW-1:0];
            clip_q = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_i     <= SEED_I;
            lfsr_q     <= SEED_Q;
            sample_cnt <= '0;
            s1_valid   <= 1'b0;
            s1_nen     <= 1'b0;
            s1_i       <= '0;
            s1_q       <= '0;
            s1_si      <= '0;
            s1_sq      <= '0;
            s1_sigma   <= '0;
            s2_valid   <= 1'b0;
            s2_i       <= '0;
            s2_q       <= '0;
            s2_ni      <= '0;
            s2_nq      <= '0;
            out_valid  <= 1'b0;
            out_i      <= '0;
            out_q      <= '0;
            out_sat    <= 1'b0;
        end else begin
            if (accept) begin
                lfsr_i     <= lfsr_adv8(lfsr_i);
                lfsr_q     <= lfsr_adv8(lfsr_q);
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (pipe_en) begin
                s1_valid <= accept;
                s1_nen   <= noise_en;
                s1_i     <= in_i;
                s1_q     <= in_q;
                s1_si    <= uni_sum(lfsr_i);
                s1_sq    <= uni_sum(lfsr_q);
                s1_sigma <= sigma_lut(snr_db);

                s2_valid <= s1_valid;
                s2_i     <= s1_i;
                s2_q     <= s1_q;
                s2_ni    <= s1_nen ? (DW+2)'(p_i >>> NOISE_SHIFT) : '0;
                s2_nq    <= s1_nen ? (DW+2)'(p_q >>> NOISE_SHIFT) : '0;

                out_valid <= s2_valid;
                out_i     <= sat_i;
                out_q     <= sat_q;
                out_sat   <= clip_i || clip_q;
            end
        end
    end

endmodule
